// File: rtl/i2s_pkg.sv
// ============================================================================
// i2s_pkg : shared defaults, sample-pair type and sequencer state type
// Revision: 1.0
// ============================================================================
`default_nettype none

package i2s_pkg;

  localparam int c_resolution  = 24;
  localparam int c_sclk_div    = 8;
  localparam int c_bits_per_ch = 32;

  typedef struct packed {
    logic [c_resolution-1:0] l;
    logic [c_resolution-1:0] r;
  } i2s_pair_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

endpackage

`default_nettype wire

// File: rtl/i2s_clk_gen.sv
// ============================================================================
// i2s_clk_gen : SCLK/LRCK generator with divider d, bit counter b, frame tick
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int SCLK_DIV    = c_sclk_div,
  parameter int BITS_PER_CH = c_bits_per_ch
) (
  input  logic CLK,
  input  logic RST,
  input  logic en,
  output logic SCLK,
  output logic LRCK,
  output logic frame_tick
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = $clog2(2 * BITS_PER_CH);

  localparam logic [DW-1:0] c_d_one     = DW'(1);
  localparam logic [DW-1:0] c_d_last    = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] c_d_half_m1 = DW'(SCLK_DIV / 2 - 1);
  localparam logic [BW-1:0] c_b_one     = BW'(1);
  localparam logic [BW-1:0] c_b_last    = BW'(2 * BITS_PER_CH - 1);
  localparam logic [BW-1:0] c_b_half_m1 = BW'(BITS_PER_CH - 1);

  i2s_state_e    r_state;
  logic [DW-1:0] r_d;
  logic [BW-1:0] r_b;
  logic          w_d_wrap;
  logic          w_b_wrap;

  assign w_d_wrap   = (r_d == c_d_last);
  assign w_b_wrap   = (r_b == c_b_last);
  assign frame_tick = !RST && en && ((r_state == ST_IDLE) || (w_d_wrap && w_b_wrap));

  // Leaving idle behaves like a falling edge already taken: d resumes at 1.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      r_state <= ST_IDLE;
      r_d     <= '0;
      r_b     <= '0;
      SCLK    <= 1'b0;
      LRCK    <= 1'b1;
    end else if (r_state == ST_IDLE) begin
      r_state <= ST_RUN;
      r_d     <= c_d_one;
      r_b     <= '0;
      SCLK    <= (c_d_one == DW'(SCLK_DIV / 2));
      LRCK    <= 1'b0;
    end else if (w_d_wrap) begin
      r_d  <= '0;
      SCLK <= 1'b0;
      if (w_b_wrap) begin
        r_b  <= '0;
        LRCK <= 1'b0;
      end else begin
        r_b <= r_b + c_b_one;
        if (r_b == c_b_half_m1) begin
          LRCK <= 1'b1;
        end
      end
    end else begin
      r_d <= r_d + c_d_one;
      if (r_d == c_d_half_m1) begin
        SCLK <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/i2s_tx_sequencer.sv
// ============================================================================
// i2s_tx_sequencer : I2S master timing, one-deep pending buffer, frame loads
// Option: define I2S_TX_UNDERRUN_CNT_EN for the saturating underrun_count port
// Revision: 1.0
// ============================================================================
`default_nettype none

module i2s_tx_sequencer
  import i2s_pkg::*;
#(
  parameter int RESOLUTION  = c_resolution,
  parameter int SCLK_DIV    = c_sclk_div,
  parameter int BITS_PER_CH = c_bits_per_ch
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [RESOLUTION-1:0] in_L,
  input  logic [RESOLUTION-1:0] in_R,
  output logic                  SCLK,
  output logic                  LRCK,
  output logic [RESOLUTION-1:0] data_L,
  output logic [RESOLUTION-1:0] data_R,
  output logic                  frame_start,
  output logic                  underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_count
`endif
);

  typedef struct packed {
    logic [RESOLUTION-1:0] l;
    logic [RESOLUTION-1:0] r;
  } pair_t;

  logic  w_frame_tick;
  logic  w_accept;
  pair_t r_pending;
  pair_t r_data;
  logic  r_pending_full;
  logic  r_frame_start;
  logic  r_underrun;

  i2s_clk_gen #(
    .SCLK_DIV    (SCLK_DIV),
    .BITS_PER_CH (BITS_PER_CH)
  ) u_clk_gen (
    .CLK        (CLK),
    .RST        (RST),
    .en         (en),
    .SCLK       (SCLK),
    .LRCK       (LRCK),
    .frame_tick (w_frame_tick)
  );

  assign w_accept = in_valid && !r_pending_full;

  // A load and an accept may share an edge only when pending is empty; the
  // new pair then waits for the following frame instead of bypassing.
  always_ff @(posedge CLK) begin
    if (RST || !en) begin
      r_pending      <= '0;
      r_pending_full <= 1'b0;
      r_data         <= '0;
      r_frame_start  <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_frame_start <= w_frame_tick;
      r_underrun    <= w_frame_tick && !r_pending_full;
      if (w_frame_tick) begin
        r_data <= r_pending_full ? r_pending : '0;
      end
      if (w_accept) begin
        r_pending.l    <= in_L;
        r_pending.r    <= in_R;
        r_pending_full <= 1'b1;
      end else if (w_frame_tick) begin
        r_pending_full <= 1'b0;
      end
    end
  end

  assign in_ready    = !r_pending_full;
  assign data_L      = r_data.l;
  assign data_R      = r_data.r;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_count;

  // Survives en=0 so software can read the total after stopping the stream.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_underrun_count <= '0;
    end else if (r_underrun && (r_underrun_count != 16'hFFFF)) begin
      r_underrun_count <= r_underrun_count + 16'd1;
    end
  end

  assign underrun_count = r_underrun_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_i2s_tx_sequencer.sv
// ============================================================================
// tb_i2s_tx_sequencer : directed stimulus, frame-position model, per-cycle compare
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_i2s_tx_sequencer;

  localparam int RES   = 24;
  localparam int DIV   = 8;
  localparam int BPC   = 32;
  localparam int FRAME = 2 * BPC * DIV;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic           en = 1'b0;
  logic           in_valid = 1'b0;
  logic [RES-1:0] in_L = '0;
  logic [RES-1:0] in_R = '0;
  logic           in_ready;
  logic           SCLK;
  logic           LRCK;
  logic [RES-1:0] data_L;
  logic [RES-1:0] data_R;
  logic           frame_start;
  logic           underrun;
`ifdef I2S_TX_UNDERRUN_CNT_EN
  logic [15:0]    underrun_count;
`endif

  i2s_tx_sequencer #(
    .RESOLUTION  (RES),
    .SCLK_DIV    (DIV),
    .BITS_PER_CH (BPC)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_L        (in_L),
    .in_R        (in_R),
    .SCLK        (SCLK),
    .LRCK        (LRCK),
    .data_L      (data_L),
    .data_R      (data_R),
    .frame_start (frame_start),
`ifdef I2S_TX_UNDERRUN_CNT_EN
    .underrun_count (underrun_count),
`endif
    .underrun    (underrun)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: outputs follow from the number of enabled edges since start-up.
  int             k = -1;
  bit             m_valid = 1'b0;
  bit             m_full = 1'b0;
  logic [RES-1:0] m_pl = '0, m_pr = '0;
  logic [RES-1:0] e_dl = '0, e_dr = '0;
  bit             e_sclk = 1'b0, e_lrck = 1'b1, e_fs = 1'b0, e_ur = 1'b0, e_ready = 1'b1;
  int             e_cnt = 0;

  always @(posedge CLK) begin : model
    int pos;
    bit boundary, accept, prev_ur;
    prev_ur = e_ur;
    m_valid = 1'b1;
    if (RST) e_cnt = 0;
    else if (prev_ur && e_cnt < 65535) e_cnt++;
    if (RST || !en) begin
      k = -1; e_sclk = 0; e_lrck = 1; m_full = 0;
      e_dl = '0; e_dr = '0; e_fs = 0; e_ur = 0;
    end else begin
      k++;
      pos      = (k + 1) % FRAME;
      boundary = (k == 0) || (pos == 0);
      e_sclk   = (pos % DIV) >= DIV / 2;
      e_lrck   = (pos / DIV) >= BPC;
      accept   = in_valid && !m_full;
      e_fs     = boundary;
      e_ur     = boundary && !m_full;
      if (boundary) begin
        e_dl = m_full ? m_pl : '0;
        e_dr = m_full ? m_pr : '0;
      end
      if (accept) begin
        m_full = 1; m_pl = in_L; m_pr = in_R;
      end else if (boundary) begin
        m_full = 0;
      end
    end
    e_ready = !m_full;
  end

  always @(negedge CLK) begin
    if (m_valid) begin
      chk("sclk", SCLK, e_sclk);
      chk("lrck", LRCK, e_lrck);
      chk("data_L", data_L, e_dl);
      chk("data_R", data_R, e_dr);
      chk("frame_start", frame_start, e_fs);
      chk("underrun", underrun, e_ur);
      chk("in_ready", in_ready, e_ready);
`ifdef I2S_TX_UNDERRUN_CNT_EN
      chk("underrun_count", underrun_count, e_cnt);
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  int             fs_cnt, ur_cnt;
  logic [RES-1:0] last_l;

  initial begin
    step(3);
    RST = 0;
    step(1);
    chk("idle_sclk", SCLK, 0);
    chk("idle_lrck", LRCK, 1);
    chk("idle_ready", in_ready, 1);
    chk("idle_data", data_L, 0);

    // Start-up, SCLK phase, mid-frame accept, LRCK rise, first loaded frame.
    en = 1;
    step(1);
    chk("start_lrck", LRCK, 0);
    chk("start_fs", frame_start, 1);
    chk("start_ur", underrun, 1);
    step(2);
    chk("sclk_low_e2", SCLK, 0);
    step(1);
    chk("sclk_high_e3", SCLK, 1);
    in_valid = 1; in_L = 24'h123456; in_R = 24'hABCDEF;
    step(1);
    in_valid = 0;
    chk("ready_after_accept", in_ready, 0);
    step(250);
    chk("lrck_e254", LRCK, 0);
    step(1);
    chk("lrck_e255", LRCK, 1);
    step(256);
    chk("load_L", data_L, 24'h123456);
    chk("load_R", data_R, 24'hABCDEF);
    chk("load_fs", frame_start, 1);
    chk("load_ur", underrun, 0);
    chk("load_ready", in_ready, 1);
    step(1);
    chk("fs_one_cycle", frame_start, 0);
    step(511);
    chk("empty_ur", underrun, 1);
    chk("empty_data", data_L, 0);
    step(1);

    // Continuous stream for 100 frames with a distinct value offered each cycle.
    fs_cnt = 0; ur_cnt = 0; last_l = '0;
    in_valid = 1;
    for (int i = 0; i < 100 * FRAME; i++) begin
      in_L = RES'(i + 1);
      in_R = ~RES'(i + 1);
      step(1);
      if (frame_start) begin
        fs_cnt++;
        chk("stream_increasing", (data_L > last_l), 1);
        last_l = data_L;
      end
      if (underrun) ur_cnt++;
    end
    in_valid = 0;
    chk("stream_frames", fs_cnt, 100);
    chk("stream_no_underrun", ur_cnt, 0);

    // Three starved frames after a reset while enabled.
    RST = 1;
    step(1);
    chk("rst_lrck", LRCK, 1);
    chk("rst_fs", frame_start, 0);
    RST = 0;
    ur_cnt = 0;
    for (int i = 0; i < 1025; i++) begin
      step(1);
      if (underrun) ur_cnt++;
    end
    chk("starve_pulses", ur_cnt, 3);
    chk("starve_data", data_R, 0);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("starve_count", underrun_count, 3);
`endif

    // in_valid on the exact load edge with pending empty.
    step(510);
    in_valid = 1; in_L = 24'h55AA33; in_R = 24'h0F0F0F;
    step(1);
    in_valid = 0;
    chk("edge_ur", underrun, 1);
    chk("edge_data", data_L, 0);
    chk("edge_ready", in_ready, 0);
    step(512);
    chk("edge_next_L", data_L, 24'h55AA33);
    chk("edge_next_R", data_R, 24'h0F0F0F);
    chk("edge_next_ur", underrun, 0);

    // Abort mid-frame with a pending pair, then restart.
    step(100);
    in_valid = 1; in_L = 24'h777777; in_R = 24'h888888;
    step(1);
    in_valid = 0;
    chk("abort_pending", in_ready, 0);
    en = 0;
    step(1);
    chk("abort_sclk", SCLK, 0);
    chk("abort_lrck", LRCK, 1);
    chk("abort_ready", in_ready, 1);
    chk("abort_data", data_L, 0);
    step(3);
    en = 1;
    step(1);
    chk("restart_lrck", LRCK, 0);
    chk("restart_fs", frame_start, 1);
    chk("restart_ur", underrun, 1);
    chk("restart_data", data_L, 0);
    step(1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
    chk("final_count", underrun_count, 5);
`endif
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/i2s_tx_sequencer.md
# i2s_tx_sequencer

Master-mode timing and sample scheduler for the I2S transmit path. From the system clock, it generates the bit clock SCLK and word clock LRCK. It accepts stereo sample pairs over a valid/ready handshake and holds them in a one-deep pending buffer. At each frame boundary it presents a stable pair on `data_L`/`data_R`, which the downstream serial encoder consumes on SCLK falling edges. It sits between the audio DSP chain and the I2S serializer, and is the only block that owns frame timing.

## Interface
- `RESOLUTION`, 24: sample width per channel, in bits.
- `SCLK_DIV`, 8: CLK cycles per SCLK period. Even, ≥2.
- `BITS_PER_CH`, 32: SCLK periods per LRCK half-frame. ≥`RESOLUTION`+1.
- `CLK`  in  1: system clock. All logic is on its rising edge.
- `RST`  in  1: reset. Synchronous, active-high.
- `en`  in  1: run enable. When low, the block returns to the idle state.
- `in_valid`  in  1: the input pair is valid.
- `in_ready`  out  1: the pending buffer is empty.
- `in_L`, `in_R`  in  `RESOLUTION`: input sample pair.
- `SCLK`  out  1: bit clock, registered.
- `LRCK`  out  1: word clock, registered. 0 = left, 1 = right.
- `data_L`, `data_R`  out  `RESOLUTION`: pair for the serializer. Stable for a whole frame.
- `frame_start`  out  1: one-CLK pulse on each frame load.
- `underrun`  out  1: one-CLK pulse when a frame load finds the pending buffer empty.

## Operation
- **Idle state** (`RST`, or `en`=0):
  - d=0, b=0.
  - `SCLK`=0, `LRCK`=1.
  - pending empty.
  - `data_L`/`data_R`=0.
  - `frame_start`=0, `underrun`=0.
  - `in_ready`=1.
- **Divider d:** counts 0..`SCLK_DIV`-1 and wraps.
  - `SCLK` ← 1 when d moves to `SCLK_DIV`/2.
  - `SCLK` ← 0 when d wraps to 0 (the falling edge).
- **Bit counter b:** counts 0..2·`BITS_PER_CH`-1 and increments on each d wrap.
  - `LRCK` ← 0 when b wraps to 0.
  - `LRCK` ← 1 when b moves to `BITS_PER_CH`.
  - `LRCK` therefore changes only on the same CLK edge as an SCLK falling edge.
- **Frame boundary:** b wraps to 0, or the first CLK edge with `en`=1 after idle. On that edge d ← 1 and `LRCK` ← 0. The idle `LRCK`=1 therefore yields a valid first falling transition.
- **Frame load** (on a frame boundary edge):
  - Pending full: `data_L`/`data_R` ← pending, pending ← empty, `frame_start`=1.
  - Pending empty: `data_L`/`data_R` ← 0, `frame_start`=1, `underrun`=1.
- **Accept:** `in_valid` && `in_ready` writes `in_L`/`in_R` to pending, which becomes full.
- **Accept coinciding with a frame load that finds pending empty:** underrun is still flagged, and the accepted pair goes to pending for the next frame. The pair is not bypassed to the outputs.
- `in_ready` = !pending_full, from registered state only. There is no combinational path from `in_valid` to `in_ready`.
- Deasserting `en` mid-frame aborts immediately to idle and discards pending. Re-enable starts a fresh frame.

## Timing
- Frame = 2·`BITS_PER_CH`·`SCLK_DIV` CLK cycles. The default is 512, which is 48 kHz at 24.576 MHz.
- `SCLK` duty is 50%: low for d in 0..`SCLK_DIV`/2-1.
- `data_L`/`data_R` change only on frame-load edges. They are therefore stable ≥1 SCLK period before the serializer samples `LRCK` on the next falling edge, and through the entire frame.
- Throughput: at most one pair per frame. Accept-to-output latency is ≤1 frame plus 1 CLK.
- `RST` takes priority over `en`. Both take effect on the next CLK edge.

## Configuration
- `I2S_TX_UNDERRUN_CNT_EN` defined:
  - Adds the output port `underrun_count`, 16 bits.
  - It increments on each `underrun` pulse and saturates at 0xFFFF.
  - It is cleared only by `RST`; `en`=0 does not clear it.
- Macro undefined: the port and counter are absent, and only the `underrun` pulse exists.

## Structure
- The shared package `i2s_pkg` holds:
  - `RESOLUTION` default.
  - `SCLK_DIV` and `BITS_PER_CH` defaults.
  - the typedef `i2s_pair_t` (struct of L and R, `RESOLUTION` bits each).
- One sub-module, `i2s_clk_gen`: owns d, b, `SCLK` and `LRCK`, and emits a `frame_tick` strobe.
- The top level holds the pending buffer, the output registers, the flags and the optional counter.

## Test plan
- Reset, then `en`=1 with defaults: `LRCK` falls 1→0 at the first enabled edge. `SCLK` period is 8 CLK and `LRCK` period is 512 CLK. `LRCK` edges coincide with `SCLK` falls.
- Feed pair L=0x123456, R=0xABCDEF before the first boundary: `data_L`/`data_R` show it from the frame load, stable 512 CLK. `frame_start` pulses once per frame.
- Continuous `in_valid`: `in_ready` deasserts after one accept and reasserts exactly on each frame load. No pair is lost or duplicated over 100 frames.
- No input for 3 frames: 3 `underrun` pulses and outputs 0. With `I2S_TX_UNDERRUN_CNT_EN`, `underrun_count`=3.
- `in_valid` rises on the exact frame-load edge with pending empty: `underrun`=1, that pair appears at the next frame.
- `en`=0 mid-frame: on the next edge `SCLK`=0, `LRCK`=1, pending empty, outputs 0. Re-enable restarts with the 1→0 `LRCK` edge.
